ipbase_arbit_rr_wrr_lock: RTL

- Parametrised successor to the team's adder/rotate RR arbiter core.
- Work-conserving round-robin over NUM requesters with valid/ready handshake and optional per-port weights (WRR).
- Grant is locked for whole multi-beat packets; the winner's data is muxed to one output.
- Sits in front of shared egress paths (e.g. NACK/ACK generator output) where several queues compete for one stream.

---
 rtl/ipbase_arbit_pkg.sv | 26 ++
 rtl/ipbase_arbit_rr_pick.sv | 36 +++
 rtl/ipbase_arbit_rr_wrr_lock.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ipbase_arbit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ipbase_arbit_pkg
// Purpose  : Shared types and helpers for the locking RR/WRR arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package ipbase_arbit_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    localparam int c_NUM_MIN = 2;
    localparam int c_NUM_MAX = 32;

    function automatic int idx_w(input int num);
        return $clog2(num);
    endfunction

    function automatic bit num_ok(input int num);
        return (num >= c_NUM_MIN) && (num <= c_NUM_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ipbase_arbit_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : ipbase_arbit_rr_pick
// Purpose  : Finds the first set request at or after a start index, wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module ipbase_arbit_rr_pick
    import ipbase_arbit_pkg::*;
#(
    parameter  int NUM = 4,
    localparam int IW  = idx_w(NUM)
) (
    input  logic [NUM-1:0] req,
    input  logic [IW-1:0]  start,
    output logic [NUM-1:0] onehot,
    output logic [IW-1:0]  idx,
    output logic           any_valid
);

    always_comb begin
        int pos;
        pos       = 0;
        idx       = '0;
        any_valid = 1'b0;
        for (int k = 0; k < NUM; k++) begin
            pos = (int'(start) + k) % NUM;
            if (!any_valid && req[pos]) begin
                any_valid = 1'b1;
                idx       = IW'(pos);
            end
        end
        onehot = any_valid ? (NUM'(1) << idx) : '0;
    end

endmodule
`default_nettype wire

// File: rtl/ipbase_arbit_rr_wrr_lock.sv
`default_nettype none
// ============================================================================
// Module   : ipbase_arbit_rr_wrr_lock
// Purpose  : Packet-locking round-robin / weighted round-robin arbiter + mux.
// Revision : 1.0 - initial release
// ============================================================================
module ipbase_arbit_rr_wrr_lock
    import ipbase_arbit_pkg::*;
#(
    parameter  int NUM  = 4,
    parameter  int DW   = 64,
    parameter  int WW   = 4,
    parameter  int MODE = 0,
    localparam int IW   = idx_w(NUM)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM-1:0]    req_valid,
    input  logic [NUM-1:0]    req_last,
    input  logic [NUM*DW-1:0] req_data,
    output logic [NUM-1:0]    req_ready,
    input  logic [NUM*WW-1:0] cfg_weight,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_data,
    output logic              out_last,
    output logic [IW-1:0]     out_src,
    output logic              busy
);

    localparam logic [WW:0] c_CRED_ONE = (WW+1)'(1);

    generate
        if (!num_ok(NUM)) begin : g_num_range_err
            $error("ipbase_arbit_rr_wrr_lock: NUM out of range");
        end
    endgenerate

    logic [DW-1:0] w_data   [NUM];
    logic [WW-1:0] w_weight [NUM];

    for (genvar g = 0; g < NUM; g++) begin : g_unpack
        assign w_data[g]   = req_data[g*DW +: DW];
        assign w_weight[g] = cfg_weight[g*WW +: WW];
    end

    arb_state_t    r_state, w_state_nxt;
    logic [IW-1:0] r_ptr, w_ptr_nxt;
    logic [IW-1:0] r_owner, w_owner_nxt;
    logic [IW-1:0] r_holder, w_holder_nxt;
    logic [WW:0]   r_credit, w_credit_nxt;

    logic [NUM-1:0] w_pick_onehot;
    logic [IW-1:0]  w_pick_idx;
    logic           w_any;

    ipbase_arbit_rr_pick #(
        .NUM (NUM)
    ) u_pick (
        .req       (req_valid),
        .start     (r_ptr),
        .onehot    (w_pick_onehot),
        .idx       (w_pick_idx),
        .any_valid (w_any)
    );

    logic [IW-1:0] w_sel;
    logic [WW-1:0] w_weight_sel;
    logic [WW:0]   w_load_val;
    logic          w_load;
    logic [WW:0]   w_cred_eff;
    logic [WW:0]   w_cred_base;
    logic [WW:0]   w_cred_left;
    logic [IW-1:0] w_ptr_inc;
    logic [IW-1:0] w_ptr_end;

    assign w_sel        = (r_state == ARB_LOCKED) ? r_owner : w_pick_idx;
    assign w_weight_sel = w_weight[w_pick_idx];

    // A zero weight still earns one packet per turn; plain RR always loads one.
    assign w_load_val   = ((MODE == 0) || (w_weight_sel == '0)) ? c_CRED_ONE
                                                               : {1'b0, w_weight_sel};
    assign w_load       = (w_pick_idx != r_holder) || (r_credit == '0);
    assign w_cred_eff   = w_load ? w_load_val : r_credit;
    assign w_cred_base  = (r_state == ARB_IDLE) ? w_cred_eff : r_credit;
    assign w_cred_left  = (w_cred_base == '0) ? '0 : w_cred_base - 1'b1;
    assign w_ptr_inc    = (w_sel == IW'(NUM - 1)) ? '0 : w_sel + 1'b1;
    assign w_ptr_end    = (w_cred_left == '0) ? w_ptr_inc : w_sel;

    always_comb begin
        out_valid    = 1'b0;
        req_ready    = '0;
        out_data     = '0;
        out_last     = 1'b0;
        out_src      = '0;
        busy         = 1'b0;
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_owner_nxt  = r_owner;
        w_holder_nxt = r_holder;
        w_credit_nxt = r_credit;

        if (!rst) begin
            out_data = w_data[w_sel];
            out_last = req_last[w_sel];
            out_src  = w_sel;
            case (r_state)
                ARB_IDLE: begin
                    out_valid = w_any;
                    req_ready = w_pick_onehot & {NUM{out_ready}};
                    // Credit load and holder change commit only with a transfer.
                    if (w_any && out_ready) begin
                        w_holder_nxt = w_sel;
                        if (req_last[w_sel]) begin
                            w_credit_nxt = w_cred_left;
                            w_ptr_nxt    = w_ptr_end;
                        end else begin
                            w_state_nxt  = ARB_LOCKED;
                            w_owner_nxt  = w_sel;
                            w_credit_nxt = w_cred_eff;
                        end
                    end
                end
                ARB_LOCKED: begin
                    busy               = 1'b1;
                    out_valid          = req_valid[r_owner];
                    req_ready[r_owner] = out_ready;
                    if (req_valid[r_owner] && out_ready && req_last[r_owner]) begin
                        w_state_nxt  = ARB_IDLE;
                        w_credit_nxt = w_cred_left;
                        w_ptr_nxt    = w_ptr_end;
                    end
                end
                default: w_state_nxt = ARB_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ARB_IDLE;
            r_ptr    <= '0;
            r_owner  <= '0;
            r_holder <= '0;
            r_credit <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_owner  <= w_owner_nxt;
            r_holder <= w_holder_nxt;
            r_credit <= w_credit_nxt;
        end
    end

endmodule
`default_nettype wire
